traffic_lights_sched: RTL and testbench
=======================================

Name: traffic_lights_sched

Overview:
Command scheduler and arbiter sitting in front of traffic_lights in the clk_0m002 domain; drives its cmd_type/cmd_val/cmd_data inputs.
- After reset, programs the light timings, then switches the controller ON.
- Runs an autonomous day/night cycle: normal operation alternates with unregulated (yellow blink) mode.
- Shares the single command port with a host requester; the host can hold the schedule off.

Parameters:
GREEN_MS, 16'd20, green time loaded at init (cmd_type 3)
RED_MS, 16'd30, red time loaded at init (cmd_type 4)
YELLOW_MS, 16'd10, yellow time loaded at init (cmd_type 5)
DAY_CYCLES, 400, clk_0m002 cycles spent in DAY before switching to NIGHT (>=2)
NIGHT_CYCLES, 200, clk_0m002 cycles spent in NIGHT before switching to DAY (>=2)

Ports:
clk_0m002  input  1  2 kHz system clock
srst_i  input  1  reset, asynchronous, active-high
host_cmd_type_i  input  3  host command type (0 ON, 1 OFF, 2 unregulated, 3/4/5 set green/red/yellow ms, 6/7 reserved)
host_cmd_data_i  input  16  host command data (ms, types 3-5 only)
host_cmd_val_i  input  1  host command valid
host_cmd_ready_o  output  1  host command accepted this cycle when val&ready
cmd_type_o  output  3  to traffic_lights cmd_type_i
cmd_val_o  output  1  to traffic_lights cmd_val_i, single-cycle pulse per command
cmd_data_o  output  16  to traffic_lights cmd_data_i
phase_o  output  2  0 INIT, 1 DAY, 2 NIGHT, 3 HOLD

Behaviour:
- One clock; srst_i is asynchronous and active-high. Reset clears all state immediately, regardless of phase or timer value.
- Reset values: cmd_val_o=0, cmd_type_o=0, cmd_data_o=0, host_cmd_ready_o=0, phase_o=0, timer=0, pending=0, FSM=CFG_G.
- All outputs are registered. A command issued in cycle N appears on cmd_*_o in cycle N+1, with cmd_val_o high for exactly one cycle.
- At most one command is issued per cycle. cmd_data_o is 0 for types 0/1/2.

FSM:
- CFG_G: issue (3, GREEN_MS), then go to CFG_R.
- CFG_R: issue (4, RED_MS), then go to CFG_Y.
- CFG_Y: issue (5, YELLOW_MS), then go to START.
- START: issue (0, 0), then go to DAY with timer=0.
- DAY: timer increments each cycle. At timer==DAY_CYCLES-1, raise pending event "NIGHT"; when it is issued, issue (2, 0), go to NIGHT, timer=0.
- NIGHT: symmetric. At timer==NIGHT_CYCLES-1, raise pending "DAY"; when it is issued, issue (0, 0), go to DAY, timer=0.
- HOLD: timer frozen at 0, no scheduled events.
- INIT (CFG_G..START) drives phase_o=0. INIT issues back-to-back in four consecutive cycles; the first cmd_val_o is in cycle 1 after reset release.

Host arbitration:
- host_cmd_ready_o=0 during INIT and 1 otherwise (registered from the next FSM state).
- Host has priority over a scheduled event in the same cycle. The scheduled event stays pending and issues the first cycle with no host accept. The timer restarts only when the event actually issues.
- Host types 3/4/5 are forwarded unchanged; the phase is unaffected.
- Host type 1 (OFF) is forwarded, FSM goes to HOLD, and any pending event is cleared.
- Host type 2 is forwarded, FSM goes to HOLD, and any pending event is cleared.
- Host type 0 (ON) is forwarded, FSM goes to DAY with timer=0, and any pending event is cleared.
- Host types 6/7 are accepted (ready=1) but dropped: no cmd_val_o and no state change.

Timer:
- Width is $clog2(max(DAY_CYCLES, NIGHT_CYCLES)).
- The timer saturates at the terminal value while an event is pending; it never wraps.

Test Plan:
1. Reset release with host idle -> cmd_val_o pulses on cycles 1..4 with (3,20), (4,30), (5,10), (0,0). phase_o goes 0→1 on cycle 4. host_cmd_ready_o=0 until then.
2. Run idle with defaults -> (2,0) exactly 400 cycles after the ON pulse and phase_o=2; (0,0) 200 cycles later and phase_o=1; pattern repeats.
3. Host holds val with (4,50) on the cycle the NIGHT event fires -> next cycle (4,50) is output. The following cycle (2,0) is output, and NIGHT timing counts from that cycle.
4. Host OFF (1) in DAY -> (1,0) output and phase_o=3. No scheduled commands for 1000 cycles. Host ON (0) -> (0,0) output, phase_o=1, NIGHT 400 cycles later.
5. Host type 6 in DAY -> ready=1, no cmd_val_o, phase and timer unchanged.
6. Assert srst_i mid-NIGHT, asynchronously between clock edges -> outputs clear immediately without waiting for an edge. After release, the INIT sequence of scenario 1 repeats exactly.

Source files
------------

// File: rtl/traffic_lights_sched_if.sv
// rtl/traffic_lights_sched_if.sv - host command port and traffic_lights command port bundle
//
// Purpose: carries the host requester handshake, the command stream towards
//          traffic_lights and the phase indication of traffic_lights_sched.
// Signals:
//   host_cmd_type_i  [2:0]   host command type
//   host_cmd_data_i  [15:0]  host command data (ms, types 3-5)
//   host_cmd_val_i           host command valid
//   host_cmd_ready_o         host command accepted when val & ready
//   cmd_type_o       [2:0]   command type to traffic_lights
//   cmd_val_o                single-cycle command strobe to traffic_lights
//   cmd_data_o       [15:0]  command data to traffic_lights
//   phase_o          [1:0]   0 INIT, 1 DAY, 2 NIGHT, 3 HOLD
// Modports: slave = scheduler side, master = host/environment side.
interface traffic_lights_sched_if;
    logic [2:0]  host_cmd_type_i;
    logic [15:0] host_cmd_data_i;
    logic        host_cmd_val_i;
    logic        host_cmd_ready_o;
    logic [2:0]  cmd_type_o;
    logic        cmd_val_o;
    logic [15:0] cmd_data_o;
    logic [1:0]  phase_o;

    modport slave (
        input  host_cmd_type_i,
        input  host_cmd_data_i,
        input  host_cmd_val_i,
        output host_cmd_ready_o,
        output cmd_type_o,
        output cmd_val_o,
        output cmd_data_o,
        output phase_o
    );

    modport master (
        output host_cmd_type_i,
        output host_cmd_data_i,
        output host_cmd_val_i,
        input  host_cmd_ready_o,
        input  cmd_type_o,
        input  cmd_val_o,
        input  cmd_data_o,
        input  phase_o
    );
endinterface

// File: rtl/traffic_lights_sched.sv
// rtl/traffic_lights_sched.sv - command scheduler and host arbiter in front of traffic_lights
//
// Purpose: after reset programs green/red/yellow times and switches the
//          controller ON, then alternates DAY (normal) and NIGHT (yellow
//          blink) autonomously. A host requester shares the command port,
//          has priority over scheduled events and can park the schedule in HOLD.
// Ports:
//   clk_0m002  2 kHz system clock
//   srst_i     asynchronous active-high reset
//   bus        traffic_lights_sched_if.slave (host handshake, command
//              stream to traffic_lights, phase_o)
module traffic_lights_sched #(
    parameter logic [15:0] GREEN_MS     = 16'd20,
    parameter logic [15:0] RED_MS       = 16'd30,
    parameter logic [15:0] YELLOW_MS    = 16'd10,
    parameter int          DAY_CYCLES   = 400,
    parameter int          NIGHT_CYCLES = 200
) (
    input  logic                   clk_0m002,
    input  logic                   srst_i,
    traffic_lights_sched_if.slave  bus
);

    localparam int MAX_CYCLES = (DAY_CYCLES > NIGHT_CYCLES) ? DAY_CYCLES : NIGHT_CYCLES;
    localparam int TW         = $clog2(MAX_CYCLES);
    localparam logic [TW-1:0] DAY_TERM   = TW'(DAY_CYCLES - 1);
    localparam logic [TW-1:0] NIGHT_TERM = TW'(NIGHT_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

    typedef enum logic [2:0] {
        CFG_G, CFG_R, CFG_Y, START, DAY, NIGHT, HOLD
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          pending_q, pending_d;
    logic          cmd_val_q, cmd_val_d;
    logic [2:0]    cmd_type_q, cmd_type_d;
    logic [15:0]   cmd_data_q, cmd_data_d;
    logic          ready_q, ready_d;
    logic [1:0]    phase_q, phase_d;

    logic          host_acc;
    logic          evt;

    // Only the accepted handshake counts; ready_q is already low during INIT.
    assign host_acc = bus.host_cmd_val_i & ready_q;

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        pending_d  = pending_q;
        cmd_val_d  = 1'b0;
        cmd_type_d = cmd_type_q;
        cmd_data_d = cmd_data_q;
        evt        = 1'b0;

        case (state_q)
            CFG_G: begin
                cmd_val_d  = 1'b1;
                cmd_type_d = 3'd3;
                cmd_data_d = GREEN_MS;
                state_d    = CFG_R;
            end
            CFG_R: begin
                cmd_val_d  = 1'b1;
                cmd_type_d = 3'd4;
                cmd_data_d = RED_MS;
                state_d    = CFG_Y;
            end
            CFG_Y: begin
                cmd_val_d  = 1'b1;
                cmd_type_d = 3'd5;
                cmd_data_d = YELLOW_MS;
                state_d    = START;
            end
            START: begin
                cmd_val_d  = 1'b1;
                cmd_type_d = 3'd0;
                cmd_data_d = 16'd0;
                state_d    = DAY;
                timer_d    = '0;
            end
            DAY: begin
                // Saturate at terminal so a deferred event never wraps the count.
                evt = pending_q | (timer_q == DAY_TERM);
                if (timer_q != DAY_TERM) begin
                    timer_d = timer_q + TIMER_ONE;
                end
            end
            NIGHT: begin
                evt = pending_q | (timer_q == NIGHT_TERM);
                if (timer_q != NIGHT_TERM) begin
                    timer_d = timer_q + TIMER_ONE;
                end
            end
            HOLD: begin
                timer_d   = '0;
                pending_d = 1'b0;
            end
            default: begin
                state_d = CFG_G;
                timer_d = '0;
            end
        endcase

        if (state_q == DAY || state_q == NIGHT || state_q == HOLD) begin
            if (host_acc) begin
                case (bus.host_cmd_type_i)
                    3'd0: begin
                        cmd_val_d  = 1'b1;
                        cmd_type_d = 3'd0;
                        cmd_data_d = 16'd0;
                        state_d    = DAY;
                        timer_d    = '0;
                        pending_d  = 1'b0;
                    end
                    3'd1, 3'd2: begin
                        cmd_val_d  = 1'b1;
                        cmd_type_d = bus.host_cmd_type_i;
                        cmd_data_d = 16'd0;
                        state_d    = HOLD;
                        timer_d    = '0;
                        pending_d  = 1'b0;
                    end
                    3'd3, 3'd4, 3'd5: begin
                        cmd_val_d  = 1'b1;
                        cmd_type_d = bus.host_cmd_type_i;
                        cmd_data_d = bus.host_cmd_data_i;
                        pending_d  = evt;
                    end
                    default: begin
                        // Reserved types are swallowed but still win the port.
                        pending_d = evt;
                    end
                endcase
            end else if (evt) begin
                cmd_val_d  = 1'b1;
                cmd_data_d = 16'd0;
                timer_d    = '0;
                pending_d  = 1'b0;
                if (state_q == DAY) begin
                    cmd_type_d = 3'd2;
                    state_d    = NIGHT;
                end else begin
                    cmd_type_d = 3'd0;
                    state_d    = DAY;
                end
            end
        end

        case (state_d)
            DAY:     phase_d = 2'd1;
            NIGHT:   phase_d = 2'd2;
            HOLD:    phase_d = 2'd3;
            default: phase_d = 2'd0;
        endcase
        ready_d = (state_d == DAY) || (state_d == NIGHT) || (state_d == HOLD);
    end

    always_ff @(posedge clk_0m002 or posedge srst_i) begin
        if (srst_i) begin
            state_q    <= CFG_G;
            timer_q    <= '0;
            pending_q  <= 1'b0;
            cmd_val_q  <= 1'b0;
            cmd_type_q <= 3'd0;
            cmd_data_q <= 16'd0;
            ready_q    <= 1'b0;
            phase_q    <= 2'd0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            pending_q  <= pending_d;
            cmd_val_q  <= cmd_val_d;
            cmd_type_q <= cmd_type_d;
            cmd_data_q <= cmd_data_d;
            ready_q    <= ready_d;
            phase_q    <= phase_d;
        end
    end

    assign bus.cmd_val_o        = cmd_val_q;
    assign bus.cmd_type_o       = cmd_type_q;
    assign bus.cmd_data_o       = cmd_data_q;
    assign bus.host_cmd_ready_o = ready_q;
    assign bus.phase_o          = phase_q;

endmodule

// File: tb/tb_traffic_lights_sched.sv
// tb/tb_traffic_lights_sched.sv - directed self-checking bench for traffic_lights_sched
module tb_traffic_lights_sched;

    logic clk_0m002 = 1'b0;
    logic srst_i    = 1'b1;
    int   total     = 0;
    int   bad       = 0;

    traffic_lights_sched_if bus();

    traffic_lights_sched dut (
        .clk_0m002 (clk_0m002),
        .srst_i    (srst_i),
        .bus       (bus)
    );

    always #5 clk_0m002 = ~clk_0m002;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_0m002);
        #1;
    endtask

    task automatic host_set(input logic val, input logic [2:0] t, input logic [15:0] d);
        bus.host_cmd_val_i  = val;
        bus.host_cmd_type_i = t;
        bus.host_cmd_data_i = d;
    endtask

    // Steps until a cmd_val_o pulse; n = steps taken, or -1 if none within lim.
    task automatic wait_cmd(input int lim, output int n);
        n = -1;
        for (int i = 1; i <= lim; i++) begin
            step();
            if (bus.cmd_val_o === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    // Steps n cycles and returns the number of cmd_val_o pulses seen.
    task automatic quiet(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (bus.cmd_val_o === 1'b1) pulses++;
        end
    endtask

    // Expects INIT sequence starting at the next edge after reset release.
    task automatic init_seq(input string pfx);
        logic [2:0]  et [4];
        logic [15:0] ed [4];
        et = '{3'd3, 3'd4, 3'd5, 3'd0};
        ed = '{16'd20, 16'd30, 16'd10, 16'd0};
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("%s_val%0d", pfx, i + 1), 32'(bus.cmd_val_o), 32'd1);
            chk($sformatf("%s_type%0d", pfx, i + 1), 32'(bus.cmd_type_o), 32'(et[i]));
            chk($sformatf("%s_data%0d", pfx, i + 1), 32'(bus.cmd_data_o), 32'(ed[i]));
            chk($sformatf("%s_phase%0d", pfx, i + 1), 32'(bus.phase_o), (i == 3) ? 32'd1 : 32'd0);
            chk($sformatf("%s_ready%0d", pfx, i + 1), 32'(bus.host_cmd_ready_o), (i == 3) ? 32'd1 : 32'd0);
        end
        step();
        chk({pfx, "_no5th"}, 32'(bus.cmd_val_o), 32'd0);
    endtask

    initial begin
        int n;
        int p;
        host_set(1'b0, 3'd0, 16'd0);

        // Reset state
        step(); step(); step();
        chk("rst_val", 32'(bus.cmd_val_o), 32'd0);
        chk("rst_type", 32'(bus.cmd_type_o), 32'd0);
        chk("rst_data", 32'(bus.cmd_data_o), 32'd0);
        chk("rst_ready", 32'(bus.host_cmd_ready_o), 32'd0);
        chk("rst_phase", 32'(bus.phase_o), 32'd0);

        // 1: INIT sequence (ON pulse at cycle 4; one extra step taken)
        srst_i = 1'b0;
        init_seq("init");

        // 2: idle day/night cycle; one step already past the ON pulse
        wait_cmd(500, n);
        chk("night1_dist", 32'(n + 1), 32'd400);
        chk("night1_type", 32'(bus.cmd_type_o), 32'd2);
        chk("night1_data", 32'(bus.cmd_data_o), 32'd0);
        chk("night1_phase", 32'(bus.phase_o), 32'd2);
        step();
        chk("pulse_width", 32'(bus.cmd_val_o), 32'd0);
        wait_cmd(300, n);
        chk("day1_dist", 32'(n + 1), 32'd200);
        chk("day1_type", 32'(bus.cmd_type_o), 32'd0);
        chk("day1_phase", 32'(bus.phase_o), 32'd1);
        wait_cmd(500, n);
        chk("night2_dist", 32'(n), 32'd400);
        chk("night2_type", 32'(bus.cmd_type_o), 32'd2);
        wait_cmd(300, n);
        chk("day2_dist", 32'(n), 32'd200);

        // 3: host (4,50) collides with the NIGHT event
        quiet(399, p);
        chk("s3_quiet", 32'(p), 32'd0);
        host_set(1'b1, 3'd4, 16'd50);
        step();
        host_set(1'b0, 3'd0, 16'd0);
        chk("s3_host_val", 32'(bus.cmd_val_o), 32'd1);
        chk("s3_host_type", 32'(bus.cmd_type_o), 32'd4);
        chk("s3_host_data", 32'(bus.cmd_data_o), 32'd50);
        chk("s3_host_phase", 32'(bus.phase_o), 32'd1);
        step();
        chk("s3_evt_val", 32'(bus.cmd_val_o), 32'd1);
        chk("s3_evt_type", 32'(bus.cmd_type_o), 32'd2);
        chk("s3_evt_phase", 32'(bus.phase_o), 32'd2);
        wait_cmd(300, n);
        chk("s3_day_dist", 32'(n), 32'd200);
        chk("s3_day_type", 32'(bus.cmd_type_o), 32'd0);

        // 5: reserved host type 6 in DAY
        quiet(100, p);
        chk("s5_quiet", 32'(p), 32'd0);
        host_set(1'b1, 3'd6, 16'd99);
        chk("s5_ready", 32'(bus.host_cmd_ready_o), 32'd1);
        step();
        host_set(1'b0, 3'd0, 16'd0);
        chk("s5_no_val", 32'(bus.cmd_val_o), 32'd0);
        chk("s5_phase", 32'(bus.phase_o), 32'd1);
        wait_cmd(400, n);
        chk("s5_night_dist", 32'(n), 32'd299);
        chk("s5_night_type", 32'(bus.cmd_type_o), 32'd2);
        wait_cmd(300, n);
        chk("s5_day_dist", 32'(n), 32'd200);

        // 4: host OFF in DAY, long hold, host ON
        quiet(50, p);
        host_set(1'b1, 3'd1, 16'd7);
        step();
        host_set(1'b0, 3'd0, 16'd0);
        chk("s4_off_val", 32'(bus.cmd_val_o), 32'd1);
        chk("s4_off_type", 32'(bus.cmd_type_o), 32'd1);
        chk("s4_off_data", 32'(bus.cmd_data_o), 32'd0);
        chk("s4_off_phase", 32'(bus.phase_o), 32'd3);
        quiet(1000, p);
        chk("s4_hold_quiet", 32'(p), 32'd0);
        chk("s4_hold_phase", 32'(bus.phase_o), 32'd3);
        chk("s4_hold_ready", 32'(bus.host_cmd_ready_o), 32'd1);
        host_set(1'b1, 3'd0, 16'h1234);
        step();
        host_set(1'b0, 3'd0, 16'd0);
        chk("s4_on_val", 32'(bus.cmd_val_o), 32'd1);
        chk("s4_on_type", 32'(bus.cmd_type_o), 32'd0);
        chk("s4_on_data", 32'(bus.cmd_data_o), 32'd0);
        chk("s4_on_phase", 32'(bus.phase_o), 32'd1);
        wait_cmd(500, n);
        chk("s4_night_dist", 32'(n), 32'd400);
        chk("s4_night_type", 32'(bus.cmd_type_o), 32'd2);

        // 6: asynchronous reset mid-NIGHT, between edges
        quiet(50, p);
        chk("s6_pre_phase", 32'(bus.phase_o), 32'd2);
        chk("s6_pre_type", 32'(bus.cmd_type_o), 32'd2);
        #2;
        srst_i = 1'b1;
        #1;
        chk("s6_async_phase", 32'(bus.phase_o), 32'd0);
        chk("s6_async_ready", 32'(bus.host_cmd_ready_o), 32'd0);
        chk("s6_async_type", 32'(bus.cmd_type_o), 32'd0);
        chk("s6_async_val", 32'(bus.cmd_val_o), 32'd0);
        step(); step();
        srst_i = 1'b0;
        init_seq("reinit");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
